// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver state encoding and bit-centre helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;
  function automatic int mid_of(input int cpb);
    return cpb / 2;
  endfunction
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: line synchroniser, start-edge detect, 3-sample majority vote
//   clk, rst        : clock, async active-high reset
//   line            : raw serial input (idle high)
//   baud_cnt, mid   : bit timer position and bit-centre index
//   start_edge      : synchronised falling edge, only after the line was seen high
//   bit_val         : majority of samples at mid-1, mid, mid+1
//   bit_strobe      : high while baud_cnt == mid+1 (bit decision point)
//   line_sync       : synchronised line level
module uart_bit_sampler #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line,
  input  logic [W-1:0] baud_cnt,
  input  logic [W-1:0] mid,
  output logic         start_edge,
  output logic         bit_val,
  output logic         bit_strobe,
  output logic         line_sync
);
  logic s1, s2, s3, v0, v1, armed;
  logic [1:0] fill;
  // fill marks when s2 carries a real line value rather than its reset value,
  // so a line held low through reset release never arms a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      v0 <= 1'b1;
      v1 <= 1'b1;
      armed <= 1'b0;
      fill <= 2'b00;
    end else begin
      s1 <= line;
      s2 <= s1;
      s3 <= s2;
      fill <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & s2);
      if (baud_cnt == mid - 1'b1) v0 <= s2;
      if (baud_cnt == mid) v1 <= s2;
    end
  end
  assign start_edge = armed & s3 & ~s2;
  assign bit_strobe = baud_cnt == mid + 1'b1;
  assign bit_val    = (v0 & v1) | (v0 & s2) | (v1 & s2);
  assign line_sync  = s2;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with error/break detection and valid/ready holding register
//   clk, rst                  : clock, async active-high reset
//   uart_rx                   : serial line, idle high
//   rx_data, rx_valid         : held payload, valid until accepted by rx_ready
//   parity_err, frame_err     : flags qualifying rx_data
//   overrun, break_det        : single-cycle event pulses
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);
  localparam int W = $clog2(CLK_PER_BIT);
  localparam logic [W-1:0] MID_V = W'(mid_of(CLK_PER_BIT));
  localparam logic [W-1:0] LAST_V = W'(CLK_PER_BIT - 1);
  state_t state;
  logic [W-1:0] baud_cnt;
  logic [DATA_BITS-1:0] sh;
  logic [3:0] idx;
  logic stop_idx, par_acc, zero, perr, ferr;
  logic start_edge, bit_val, bit_strobe, line_sync;
  uart_bit_sampler #(.W(W)) u_sampler (
    .clk(clk),
    .rst(rst),
    .line(uart_rx),
    .baud_cnt(baud_cnt),
    .mid(MID_V),
    .start_edge(start_edge),
    .bit_val(bit_val),
    .bit_strobe(bit_strobe),
    .line_sync(line_sync)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      baud_cnt <= '0;
      sh <= '0;
      idx <= '0;
      stop_idx <= 1'b0;
      par_acc <= 1'b0;
      zero <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= 1'b0;
      overrun <= 1'b0;
      baud_cnt <= (state == S_IDLE || baud_cnt == LAST_V) ? '0 : baud_cnt + 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        S_IDLE: if (start_edge) state <= S_START;
        S_START: if (bit_strobe) begin
          state <= bit_val ? S_IDLE : S_DATA;
          idx <= '0;
          stop_idx <= 1'b0;
          par_acc <= 1'b0;
          zero <= 1'b1;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
        S_DATA: if (bit_strobe) begin
          sh <= {bit_val, sh[DATA_BITS-1:1]};
          par_acc <= par_acc ^ bit_val;
          zero <= zero & ~bit_val;
          idx <= idx + 1'b1;
          if (idx == 4'(DATA_BITS - 1)) state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
        S_PARITY: if (bit_strobe) begin
          perr <= bit_val ^ ((PARITY == PAR_ODD) ? ~par_acc : par_acc);
          zero <= zero & ~bit_val;
          state <= S_STOP;
        end
        S_STOP: if (bit_strobe) begin
          if (!stop_idx && zero && !bit_val) begin
            break_det <= 1'b1;
            state <= S_BRK_WAIT;
          end else if (stop_idx == 1'(STOP_BITS - 1)) begin
            // leave at the decision point so the next start edge can resync
            state <= S_IDLE;
            if (rx_valid && !rx_ready) overrun <= 1'b1;
            else begin
              rx_valid <= 1'b1;
              rx_data <= sh;
              parity_err <= perr;
              frame_err <= ferr | ~bit_val;
            end
          end else begin
            ferr <= ferr | ~bit_val;
            stop_idx <= 1'b1;
          end
        end
        S_BRK_WAIT: if (line_sync) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of uart_rx_cfg in 8N1, 8E1 and 8N2 configurations
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ln_a = 1'b1, ln_e = 1'b1, ln_s = 1'b1;
  logic rdy_a = 1'b1, rdy_e = 1'b0, rdy_s = 1'b0;
  logic [7:0] a_data, e_data, s_data;
  logic a_valid, a_perr, a_ferr, a_ovr, a_brk;
  logic e_valid, e_perr, e_ferr, e_ovr, e_brk;
  logic s_valid, s_perr, s_ferr, s_ovr, s_brk;
  int checks = 0, errors = 0, cyc = 0;
  int vcnt = 0, bcnt = 0, ocnt = 0, rise_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] last_data = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(ln_a), .rx_data(a_data), .rx_valid(a_valid), .rx_ready(rdy_a),
    .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr), .break_det(a_brk));
  uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .uart_rx(ln_e), .rx_data(e_data), .rx_valid(e_valid), .rx_ready(rdy_e),
    .parity_err(e_perr), .frame_err(e_ferr), .overrun(e_ovr), .break_det(e_brk));
  uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .uart_rx(ln_s), .rx_data(s_data), .rx_valid(s_valid), .rx_ready(rdy_s),
    .parity_err(s_perr), .frame_err(s_ferr), .overrun(s_ovr), .break_det(s_brk));
  always @(negedge clk) begin
    if (a_valid) begin
      vcnt++;
      last_data = a_data;
      if (!prev_v) rise_cyc = cyc;
    end
    prev_v = a_valid;
    if (a_brk) bcnt++;
    if (a_ovr) ocnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int w, input logic v);
    case (w)
      0: ln_a = v;
      1: ln_e = v;
      default: ln_s = v;
    endcase
  endtask
  task automatic send(input int w, input logic [7:0] d, input int np, input logic pb,
                      input int ns, input logic [1:0] sb, input int spike_j, output int c0);
    logic [15:0] fr;
    int n;
    fr = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin fr[n] = d[i]; n++; end
    if (np != 0) begin fr[n] = pb; n++; end
    for (int i = 0; i < ns; i++) begin fr[n] = sb[i]; n++; end
    @(posedge clk); #1;
    c0 = cyc;
    for (int j = 0; j < n; j++) begin
      drive(w, fr[j]);
      for (int k = 0; k < 16; k++) begin
        if (j == spike_j && k == 9) drive(w, ~fr[j]);
        if (j == spike_j && k == 10) drive(w, fr[j]);
        @(posedge clk); #1;
      end
    end
    drive(w, 1'b1);
  endtask
  initial begin
    int c0, v0, b0, o0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", a_valid, 0);
    chk("reset_data", a_data, 0);
    chk("reset_flags", {a_perr, a_ferr, a_ovr, a_brk}, 0);
    chk("reset_valid_e_s", {e_valid, s_valid}, 0);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    v0 = vcnt;
    send(0, 8'hA5, 0, 1'b0, 1, 2'b11, -1, c0);
    repeat (4) @(posedge clk);
    chk("a5_valid_cycles", vcnt - v0, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_flags", {a_perr, a_ferr}, 0);
    chk("a5_latency", rise_cyc - c0, 157);
    send(1, 8'h03, 1, 1'b1, 1, 2'b11, -1, c0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("par_bad_valid", e_valid, 1);
    chk("par_bad_data", e_data, 8'h03);
    chk("par_bad_perr", e_perr, 1);
    chk("par_bad_ferr", e_ferr, 0);
    #1 rdy_e = 1'b1;
    @(posedge clk); #1 rdy_e = 1'b0;
    @(negedge clk);
    chk("par_accept", e_valid, 0);
    send(1, 8'h03, 1, 1'b0, 1, 2'b11, -1, c0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("par_ok_valid", e_valid, 1);
    chk("par_ok_perr", e_perr, 0);
    chk("par_ok_data", e_data, 8'h03);
    send(2, 8'h3C, 0, 1'b0, 2, 2'b01, -1, c0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stop2_valid", s_valid, 1);
    chk("stop2_ferr", s_ferr, 1);
    chk("stop2_data", s_data, 8'h3C);
    chk("stop2_perr", s_perr, 0);
    v0 = vcnt;
    @(posedge clk); #1 ln_a = 1'b0;
    repeat (5) @(posedge clk);
    #1 ln_a = 1'b1;
    repeat (40) @(posedge clk);
    chk("glitch_no_valid", vcnt - v0, 0);
    send(0, 8'h0F, 0, 1'b0, 1, 2'b11, 1, c0);
    repeat (4) @(posedge clk);
    chk("spike_valid", vcnt - v0, 1);
    chk("spike_data", last_data, 8'h0F);
    rdy_a = 1'b0;
    o0 = ocnt;
    send(0, 8'h11, 0, 1'b0, 1, 2'b11, -1, c0);
    send(0, 8'h22, 0, 1'b0, 1, 2'b11, -1, c0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovr_pulses", ocnt - o0, 1);
    chk("ovr_data_kept", a_data, 8'h11);
    chk("ovr_valid_held", a_valid, 1);
    #1 rdy_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovr_accept", a_valid, 0);
    v0 = vcnt;
    b0 = bcnt;
    @(posedge clk); #1 ln_a = 1'b0;
    repeat (192) @(posedge clk);
    #1 ln_a = 1'b1;
    repeat (32) @(posedge clk);
    chk("brk_pulses", bcnt - b0, 1);
    chk("brk_no_valid", vcnt - v0, 0);
    send(0, 8'h5A, 0, 1'b0, 1, 2'b11, -1, c0);
    repeat (4) @(posedge clk);
    chk("after_brk_valid", vcnt - v0, 1);
    chk("after_brk_data", last_data, 8'h5A);
    v0 = vcnt;
    b0 = bcnt;
    o0 = ocnt;
    fork
      send(0, 8'hFF, 0, 1'b0, 1, 2'b11, -1, c0);
      begin
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", a_data, 0);
        chk("midrst_outs", {a_valid, a_perr, a_ferr, a_ovr, a_brk}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (40) @(posedge clk);
    chk("midrst_no_valid", vcnt - v0, 0);
    chk("midrst_no_pulses", (bcnt - b0) + (ocnt - o0), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
